// File: rtl/intersection_phase_scheduler_if.sv
// Sensor, preemption and lamp signals between the intersection scheduler and its environment.
interface intersection_phase_scheduler_if;
   logic       ns_car;
   logic       ew_car;
   logic       emg_req;
   logic       emg_dir;
   logic [2:0] ns_light;
   logic [2:0] ew_light;
   logic [2:0] phase;
   logic       emg_active;

   modport master (
      output ns_car, ew_car, emg_req, emg_dir,
      input  ns_light, ew_light, phase, emg_active
   );

   modport slave (
      input  ns_car, ew_car, emg_req, emg_dir,
      output ns_light, ew_light, phase, emg_active
   );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven NS/EW green scheduler with min/max green, yellow and all-red clearance,
// and emergency preemption. All outputs are registered.
module intersection_phase_scheduler #(
   parameter int unsigned MIN_GREEN = 8,
   parameter int unsigned MAX_GREEN = 20,
   parameter int unsigned YELLOW_T  = 3,
   parameter int unsigned CLEAR_T   = 2,
   parameter int unsigned TW        = 8
) (
   input logic                          clk,
   input logic                          reset,
   intersection_phase_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      CLEAR     = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4
   } state_e;

   localparam logic          DIR_NS   = 1'b0;
   localparam logic          DIR_EW   = 1'b1;
   localparam logic [2:0]    LAMP_RED = 3'b100;
   localparam logic [2:0]    LAMP_YEL = 3'b010;
   localparam logic [2:0]    LAMP_GRN = 3'b001;
   localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
   localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
   localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] CLR_LAST = TW'(CLEAR_T - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          last_dir_q, last_dir_d;
   logic          ns_pend_q, ns_pend_d;
   logic          ew_pend_q, ew_pend_d;
   logic [2:0]    ns_light_q, ns_light_d;
   logic [2:0]    ew_light_q, ew_light_d;
   logic          emg_active_q, emg_active_d;

   logic emg_ns, emg_ew, ns_exit, ew_exit, next_dir, in_green;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CLEAR;
         timer_q      <= '0;
         last_dir_q   <= DIR_EW;
         ns_pend_q    <= 1'b0;
         ew_pend_q    <= 1'b0;
         ns_light_q   <= LAMP_RED;
         ew_light_q   <= LAMP_RED;
         emg_active_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         last_dir_q   <= last_dir_d;
         ns_pend_q    <= ns_pend_d;
         ew_pend_q    <= ew_pend_d;
         ns_light_q   <= ns_light_d;
         ew_light_q   <= ew_light_d;
         emg_active_q <= emg_active_d;
      end
   end

   always_comb begin
      emg_ns   = bus.emg_req & ~bus.emg_dir;
      emg_ew   = bus.emg_req &  bus.emg_dir;
      // An emergency for the opposite side cuts green short; one for the served side holds it.
      ns_exit  = emg_ew | (~emg_ns & ew_pend_q &
                 (((timer_q >= MIN_LAST) & ~bus.ns_car) | (timer_q >= MAX_LAST)));
      ew_exit  = emg_ns | (~emg_ew & ns_pend_q &
                 (((timer_q >= MIN_LAST) & ~bus.ew_car) | (timer_q >= MAX_LAST)));
      next_dir = bus.emg_req ? bus.emg_dir : ~last_dir_q;
      in_green = (state_q == NS_GREEN) | (state_q == EW_GREEN);

      state_d    = state_q;
      last_dir_d = last_dir_q;
      case (state_q)
         CLEAR: begin
            if (timer_q == CLR_LAST) begin
               last_dir_d = next_dir;
               if (next_dir == DIR_EW) state_d = EW_GREEN;
               else                    state_d = NS_GREEN;
            end
         end
         NS_GREEN:  if (ns_exit)              state_d = NS_YELLOW;
         NS_YELLOW: if (timer_q == YEL_LAST) state_d = CLEAR;
         EW_GREEN:  if (ew_exit)              state_d = EW_YELLOW;
         EW_YELLOW: if (timer_q == YEL_LAST) state_d = CLEAR;
         default:                             state_d = CLEAR;
      endcase

      if (state_d != state_q)                    timer_d = '0;
      else if (in_green && timer_q == MAX_LAST) timer_d = timer_q;
      else                                       timer_d = timer_q + TW'(1);

      // Clearing on green entry takes priority over a same-cycle set.
      ns_pend_d = ns_pend_q | ((bus.ns_car | emg_ns) & (state_q != NS_GREEN));
      if (state_d == NS_GREEN && state_q != NS_GREEN) ns_pend_d = 1'b0;
      ew_pend_d = ew_pend_q | ((bus.ew_car | emg_ew) & (state_q != EW_GREEN));
      if (state_d == EW_GREEN && state_q != EW_GREEN) ew_pend_d = 1'b0;

      ns_light_d = LAMP_RED;
      ew_light_d = LAMP_RED;
      case (state_d)
         NS_GREEN:  ns_light_d = LAMP_GRN;
         NS_YELLOW: ns_light_d = LAMP_YEL;
         EW_GREEN:  ew_light_d = LAMP_GRN;
         EW_YELLOW: ew_light_d = LAMP_YEL;
         default: ;
      endcase

      emg_active_d = ((state_q == NS_GREEN) & emg_ns) | ((state_q == EW_GREEN) & emg_ew);
   end

   assign bus.phase      = state_q;
   assign bus.ns_light   = ns_light_q;
   assign bus.ew_light   = ew_light_q;
   assign bus.emg_active = emg_active_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: stimulus queues expected output changes (with dwell), a negedge monitor checks them.
module tb_intersection_phase_scheduler;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] P_CLR = 3'd0;
   localparam logic [2:0] P_NSG = 3'd1;
   localparam logic [2:0] P_NSY = 3'd2;
   localparam logic [2:0] P_EWG = 3'd3;
   localparam logic [2:0] P_EWY = 3'd4;

   typedef struct {
      string      name;
      logic [2:0] ph;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       emg;
      int         dwell;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   intersection_phase_scheduler_if bus();

   intersection_phase_scheduler #(
      .MIN_GREEN(8), .MAX_GREEN(20), .YELLOW_T(3), .CLEAR_T(2), .TW(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_fail = 0;
   bit   sb_en = 1'b1;

   function automatic void chk(input bit ok, input string nm, input string got, input string exp_s);
      n_chk++;
      if (ok) n_pass++;
      else begin
         n_fail++;
         if (n_fail <= 20) $display("FAIL %s: got %s, expected %s", nm, got, exp_s);
      end
   endfunction

   function automatic string fmt(input logic [2:0] ph, input logic [2:0] ns, input logic [2:0] ew,
                                 input logic emg, input int dw);
      return $sformatf("phase=%0d ns=%b ew=%b emg=%b dwell=%0d", ph, ns, ew, emg, dw);
   endfunction

   task automatic push(input string nm, input logic [2:0] ph, input logic [2:0] ns,
                       input logic [2:0] ew, input logic emg, input int dw);
      exp_t e;
      e.name = nm; e.ph = ph; e.ns = ns; e.ew = ew; e.emg = emg; e.dwell = dw;
      sbq.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every output change is an event; dwell is cycles since the previous one.
   int         cyc = 0;
   int         last_ev = 0;
   bit         in_rst = 1'b0;
   logic [9:0] prev_out;
   always @(negedge clk) begin
      logic [9:0] cur;
      exp_t       e;
      int         dw;
      cyc++;
      cur = {bus.phase, bus.ns_light, bus.ew_light, bus.emg_active};
      chk(!(bus.ns_light != R && bus.ew_light != R), "both_not_red",
          $sformatf("ns=%b ew=%b", bus.ns_light, bus.ew_light), "one side red");
      if (reset) begin
         in_rst = 1'b1;
      end else if (in_rst) begin
         in_rst  = 1'b0;
         last_ev = cyc;
      end else if (cur != prev_out) begin
         dw = cyc - last_ev;
         if (sb_en) begin
            if (sbq.size() == 0) begin
               chk(1'b0, "unexpected_event",
                   fmt(bus.phase, bus.ns_light, bus.ew_light, bus.emg_active, dw), "no change");
            end else begin
               e = sbq.pop_front();
               chk(bus.phase == e.ph && bus.ns_light == e.ns && bus.ew_light == e.ew &&
                   bus.emg_active == e.emg && dw == e.dwell, e.name,
                   fmt(bus.phase, bus.ns_light, bus.ew_light, bus.emg_active, dw),
                   fmt(e.ph, e.ns, e.ew, e.emg, e.dwell));
            end
         end
         last_ev = cyc;
      end
      prev_out = cur;
   end

   task automatic check_reset_vals(input string nm);
      chk(bus.phase == P_CLR, {nm, "_phase"}, $sformatf("%0d", bus.phase), "0");
      chk(bus.ns_light == R, {nm, "_ns"}, $sformatf("%b", bus.ns_light), "100");
      chk(bus.ew_light == R, {nm, "_ew"}, $sformatf("%b", bus.ew_light), "100");
      chk(bus.emg_active == 1'b0, {nm, "_emg"}, $sformatf("%b", bus.emg_active), "0");
   endtask

   initial begin
      bus.ns_car = 1'b0; bus.ew_car = 1'b0; bus.emg_req = 1'b0; bus.emg_dir = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_vals("reset");
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      // Edges counted from release: E2 first grant to NS after 2 CLEAR cycles.
      push("first_grant_ns", P_NSG, G, R, 1'b0, 2);
      tick(2);
      // Rest in NS green for 100 cycles, then a one-cycle EW demand.
      tick(100);
      bus.ew_car = 1'b1;
      push("rest_then_ns_yellow", P_NSY, Y, R, 1'b0, 102);
      push("ns_yellow_to_clear", P_CLR, R, R, 1'b0, 3);
      push("clear_to_ew_green", P_EWG, R, G, 1'b0, 2);
      tick(1);
      bus.ew_car = 1'b0;
      tick(8);
      // EW green at timer 2: NS preemption cuts it short.
      bus.emg_req = 1'b1; bus.emg_dir = 1'b0; bus.ew_car = 1'b1;
      push("emg_ew_yellow_early", P_EWY, R, Y, 1'b0, 3);
      push("emg_ew_clear", P_CLR, R, R, 1'b0, 3);
      push("emg_ns_green", P_NSG, G, R, 1'b0, 2);
      push("emg_active_rise", P_NSG, G, R, 1'b1, 1);
      tick(56);
      bus.emg_req = 1'b0;
      push("emg_drop_ns_yellow", P_NSY, Y, R, 1'b0, 50);
      push("ns_yellow_clear2", P_CLR, R, R, 1'b0, 3);
      push("ew_green2", P_EWG, R, G, 1'b0, 2);
      tick(6);
      // Min-green exit: NS demand, EW road empty.
      bus.ns_car = 1'b1; bus.ew_car = 1'b0;
      push("ew_min_green", P_EWY, R, Y, 1'b0, 8);
      push("ew_yellow_clear", P_CLR, R, R, 1'b0, 3);
      push("ns_green3", P_NSG, G, R, 1'b0, 2);
      tick(13);
      // NS occupied and EW waiting from timer 0: green runs to max.
      bus.ew_car = 1'b1;
      push("ns_max_green", P_NSY, Y, R, 1'b0, 20);
      tick(20);
      // Preemption for NS raised during NS yellow.
      bus.emg_req = 1'b1; bus.emg_dir = 1'b0; bus.ns_car = 1'b0; bus.ew_car = 1'b0;
      push("yellow_not_truncated", P_CLR, R, R, 1'b0, 3);
      push("emg_regrant_ns", P_NSG, G, R, 1'b0, 2);
      push("emg_active_rise2", P_NSG, G, R, 1'b1, 1);
      tick(9);
      bus.emg_req = 1'b0;
      push("emg_active_fall", P_NSG, G, R, 1'b0, 4);
      push("ns_min_after_emg", P_NSY, Y, R, 1'b0, 3);
      push("clear4", P_CLR, R, R, 1'b0, 3);
      push("ew_green4", P_EWG, R, G, 1'b0, 2);
      tick(9);
      bus.ns_car = 1'b1;
      push("ew_yellow5", P_EWY, R, Y, 1'b0, 8);
      tick(9);
      // Mid-yellow asynchronous reset.
      #1 reset = 1'b1;
      #1 check_reset_vals("async_reset");
      bus.ns_car = 1'b0;
      chk(sbq.size() == 0, "all_events_seen", $sformatf("%0d pending", sbq.size()), "0 pending");
      sb_en = 1'b0;
      tick(2);
      reset = 1'b0;

      for (int i = 0; i < 10000; i++) begin
         bus.ns_car  = 1'($urandom_range(0, 1));
         bus.ew_car  = 1'($urandom_range(0, 1));
         bus.emg_req = ($urandom_range(0, 9) == 0);
         bus.emg_dir = 1'($urandom_range(0, 1));
         tick(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
